// File: rtl/mfp_ip_seq.sv
// Frame sequencer: walks the source frame buffer on a start edge, drives the datapath
// through a fixed read-latency pipeline and counts results into the destination buffer.
//
// state    | meaning
// ST_IDLE  | waiting for a start edge
// ST_RUN   | issuing source reads, accepting results
// ST_DRAIN | all reads issued, waiting for the remaining results
// ST_DONE  | frame complete, done asserted until next start or abort
module mfp_ip_seq #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic [7:0]        ip_ctrl,
    input  logic              dp_ready,
    input  logic              dp_out_valid,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              px_valid,
    output logic [2:0]        px_op,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    localparam int N = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_cnt, wr_cnt;
    logic [RD_LAT-1:0] rd_pipe;
    logic              start_d;
    logic              start_pulse;
    logic              abort;
    logic              go_run;
    logic              unused_ctrl;

    assign start_pulse = ip_ctrl[0] & ~start_d;
    assign abort       = ip_ctrl[7];
    assign unused_ctrl = ^ip_ctrl[6:4];

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        go_run    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start_pulse) begin
                    state_nxt = ST_RUN;
                    go_run    = 1'b1;
                end
            end
            ST_RUN: begin
                rd_en = dp_ready;
                wr_en = dp_out_valid;
                // A final write can land while reads are still outstanding only in
                // degenerate cases, but it must still end the frame.
                if (wr_en && wr_cnt == LAST)
                    state_nxt = ST_DONE;
                else if (rd_en && rd_cnt == LAST)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                wr_en = dp_out_valid;
                if (wr_en && wr_cnt == LAST)
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            go_run    = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            start_d <= 1'b0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            px_op   <= 3'b000;
        end else begin
            state   <= state_nxt;
            start_d <= ip_ctrl[0];
            if (go_run) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
                px_op  <= ip_ctrl[3:1];
            end else if (!abort) begin
                if (rd_en && rd_cnt != LAST)
                    rd_cnt <= rd_cnt + ADDR_W'(1);
                if (wr_en && wr_cnt != LAST)
                    wr_cnt <= wr_cnt + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_pipe <= '0;
        end else if (abort) begin
            rd_pipe <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--)
                rd_pipe[i] <= rd_pipe[i-1];
            rd_pipe[0] <= rd_en;
        end
    end

    assign px_valid = rd_pipe[RD_LAT-1];
    assign rd_addr  = rd_cnt;
    assign wr_addr  = wr_cnt;
    assign busy     = (state == ST_RUN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);

endmodule

// File: doc/mfp_ip_seq.md
# mfp_ip_seq

Frame sequencer for the image-processing datapath. It consumes the 8-bit IP control byte that software writes over AHB-Lite. On a start command it walks every pixel of the source frame buffer, feeds reads to the processing datapath with a fixed read-latency pipeline, and counts results back into the destination buffer. It sits between the AHB IP control register and the frame-buffer/datapath pair, and exports busy/done status for read-back.

## Interface
- IMG_W, 320, frame width in pixels
- IMG_H, 240, frame height in pixels
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- RD_LAT, 2, source frame-buffer read latency in cycles (>=1)
- HCLK  in  1  system clock; all state on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- ip_ctrl  in  8  control byte from the AHB IP register: [0] start (rising edge acts), [3:1] op code, [7] abort (level)
- dp_ready  in  1  datapath can accept a pixel this cycle
- dp_out_valid  in  1  datapath result valid this cycle
- rd_en  out  1  source read strobe
- rd_addr  out  ADDR_W  source read address
- px_valid  out  1  source data valid to datapath (rd_en delayed RD_LAT)
- px_op  out  3  latched op code to datapath
- wr_en  out  1  destination write strobe
- wr_addr  out  ADDR_W  destination write address
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE

## Operation
- N = IMG_W*IMG_H. rd_cnt and wr_cnt are ADDR_W-bit registers; rd_addr = rd_cnt, wr_addr = wr_cnt.
- Start edge: start_d registers ip_ctrl[0]; start_pulse = ip_ctrl[0] & ~start_d.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE or DONE, start_pulse & ~ip_ctrl[7]: go to RUN. Clear rd_cnt and wr_cnt; latch px_op = ip_ctrl[3:1].
- RUN:
  - rd_en = dp_ready (combinational); each rd_en increments rd_cnt.
  - rd_en with rd_cnt == N-1: go to DRAIN. rd_cnt holds at N-1; it does not wrap.
- RUN or DRAIN: wr_en = dp_out_valid (combinational); each wr_en increments wr_cnt.
  - wr_en with wr_cnt == N-1: go to DONE from either state. wr_cnt holds.
- DONE: done = 1 until the next start_pulse or abort.
- Abort: ip_ctrl[7] = 1 in any state goes to IDLE on the next edge.
  - Abort takes priority over start and over the last read or write in the same cycle.
  - The px_valid pipeline is flushed to 0 on the same edge.
- start_pulse in RUN or DRAIN is ignored; px_op does not change.
- dp_out_valid outside RUN/DRAIN is ignored: wr_en = 0 and no count.
- px_valid is an RD_LAT-deep shift register of rd_en. It continues to shift out in DRAIN/DONE after the last read unless aborted.
- Reset values: state IDLE, rd_cnt = 0, wr_cnt = 0, px_op = 0, start_d = 0, px_valid pipeline all 0.
  - Hence rd_en = wr_en = px_valid = busy = done = 0 and rd_addr = wr_addr = 0.
- Reset mid-frame returns to IDLE immediately, asynchronously. Counters clear.

## Timing
- start_pulse sampled at edge k: busy = 1 after edge k. First rd_en is possible in the cycle after edge k, with rd_addr = 0.
- px_valid for the read issued in cycle c is high in cycle c+RD_LAT.
- Throughput is 1 read/cycle while dp_ready = 1. A dp_ready low cycle stalls rd_cnt with no read.
- Last write accepted at edge m: done = 1 and busy = 0 after edge m.
- Abort high before edge a: rd_en, wr_en and busy drop to 0 immediately after edge a.
- ip_ctrl held at start = 1 produces exactly one frame. Software must drop start to 0 before re-arming.

## Test plan
- IMG_W=4, IMG_H=2, RD_LAT=2; reset with HRESETn = 0:
  - Requires all outputs 0 and busy = 0.
  - ip_ctrl = 8'h00 for 3 cycles after reset: no rd_en.
- Set ip_ctrl 8'h00 -> 8'h05 with dp_ready = 1 and dp_out_valid = px_valid:
  - px_op = 3'b010.
  - rd_addr 0..7 on 8 consecutive cycles.
  - px_valid high 2 cycles after each rd_en.
  - wr_addr 0..7.
  - done = 1 one cycle after the 8th write; busy = 0.
- Toggle dp_ready 1,0,1,0 during RUN:
  - rd_cnt advances only on ready cycles.
  - No duplicate or skipped addresses.
  - Completes with exactly 8 writes.
- Set ip_ctrl = 8'h81 after the 3rd read:
  - busy = 0 next cycle.
  - px_valid flushed; no further wr_en despite dp_out_valid = 1.
  - A fresh start after dropping [7] begins again at rd_addr = 0.
- Issue a second start edge mid-RUN with op 3'b111: ignored; px_op stays 3'b010 and the frame completes normally.
- Start and abort in the same cycle from DONE: state IDLE and done = 0. Drop HRESETn mid-DRAIN: immediate IDLE with wr_cnt = 0.
